// File: rtl/bt_msg_uart_tx.sv
// Queued ASCII status-message transmitter (8N1) for the HC-05 link.
// Requests are queued, formatted into '#'-terminated strings and serialised on o_tx.
module bt_msg_uart_tx #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [1:0]       i_req_type,
  input  logic [3:0]       i_req_unit,
  input  logic             i_node_pulse,
  input  logic             i_node_clr,
  output logic [CNT_W-1:0] o_num_nodes,
  output logic             o_tx,
  output logic             o_busy,
  output logic             o_tx_done
);
  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int TW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_POP, S_START, S_DATA, S_STOP} state_t;
  state_t r_state, w_next;

  logic [5:0]      r_fifo [FIFO_DEPTH];
  logic [AW:0]     r_wp, r_rp;
  logic            w_full, w_empty, w_push;
  logic [5:0]      w_ent;
  logic [CNT_W-1:0] r_cnt;
  logic            r_np;
  logic [TW-1:0]   r_cyc;
  logic [2:0]      r_bitn, r_idx, r_last, w_last;
  logic [7:0][7:0] r_msg, w_str;
  logic [7:0]      w_u, w_t, w_o;
  logic            w_tick, r_tx_done;
  int              w_v;

  assign w_empty     = (r_wp == r_rp);
  assign w_full      = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_push      = i_req_valid && !w_full;
  assign o_req_ready = !w_full;
  assign o_num_nodes = r_cnt;
  assign o_tx_done   = r_tx_done;
  assign w_tick      = (r_cyc == TW'(BIT_CYC - 1));
  assign w_ent       = r_fifo[r_rp[AW-1:0]];

  always_ff @(posedge clk)
    if (w_push) r_fifo[r_wp[AW-1:0]] <= {i_req_type, i_req_unit};

  // Count rising edges only; a clear in the same cycle wins.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_np  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_np <= i_node_pulse;
      if (i_node_clr)                                  r_cnt <= '0;
      else if (i_node_pulse && !r_np && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
    end

  // Message formatting from the queue head; count digits clipped to 99.
  always_comb begin
    w_u = (w_ent[3:0] > 4'd9) ? 8'h39 : (8'h30 + {4'h0, w_ent[3:0]});
    w_v = int'(r_cnt);
    if (w_v > 99) w_v = 99;
    w_t    = 8'h30 + 8'(w_v / 10);
    w_o    = 8'h30 + 8'(w_v % 10);
    w_str  = '0;
    w_last = 3'd6;
    case (w_ent[5:4])
      2'd0, 2'd1: begin
        w_str[0] = (w_ent[5:4] == 2'd0) ? "F" : "B";
        w_str[1] = (w_ent[5:4] == 2'd0) ? "I" : "D";
        w_str[2] = "M";
        w_str[3] = "-";
        w_str[4] = w_u;
        w_str[5] = "-";
        w_str[6] = "#";
        w_last   = 3'd6;
      end
      2'd2: begin
        w_str[0] = "N";
        w_str[1] = "D";
        w_str[2] = "C";
        w_str[3] = "-";
        w_str[4] = w_t;
        w_str[5] = w_o;
        w_str[6] = "-";
        w_str[7] = "#";
        w_last   = 3'd7;
      end
      default: begin
        w_str[0] = "R";
        w_str[1] = "S";
        w_str[2] = "T";
        w_str[3] = "-";
        w_str[4] = "#";
        w_last   = 3'd4;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_next = S_POP;
      S_POP:   w_next = S_START;
      S_START: if (w_tick) w_next = S_DATA;
      S_DATA:  if (w_tick && r_bitn == 3'd7) w_next = S_STOP;
      S_STOP:  if (w_tick) w_next = (r_idx == r_last) ? S_IDLE : S_START;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_tx   = 1'b1;
    o_busy = (r_state != S_IDLE);
    case (r_state)
      S_START: o_tx = 1'b0;
      S_DATA:  o_tx = r_msg[r_idx][r_bitn];
      default: o_tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_cyc     <= '0;
      r_bitn    <= '0;
      r_idx     <= '0;
      r_last    <= '0;
      r_msg     <= '0;
      r_tx_done <= 1'b0;
    end else begin
      r_tx_done <= (r_state == S_STOP) && w_tick && (r_idx == r_last);
      if (w_push) r_wp <= r_wp + 1'b1;
      if (r_state == S_POP) begin
        r_rp   <= r_rp + 1'b1;
        r_msg  <= w_str;
        r_last <= w_last;
      end
      if (r_state == S_START || r_state == S_DATA || r_state == S_STOP)
        r_cyc <= w_tick ? '0 : r_cyc + 1'b1;
      else
        r_cyc <= '0;
      if (r_state == S_DATA && w_tick) r_bitn <= r_bitn + 1'b1;
      if (r_state == S_STOP && w_tick) r_idx <= r_idx + 1'b1;
      if (r_state == S_IDLE)           r_idx <= '0;
    end
endmodule

// File: tb/tb_bt_msg_uart_tx.sv
// Self-checking bench for bt_msg_uart_tx: table of single messages plus
// hand sequences for latency, queue-full, mid-frame reset, clear priority and back-to-back frames.
module tb_bt_msg_uart_tx;
  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int BIT    = CLK_HZ / BAUD;  // 10 cycles per bit
  localparam int CNT_W  = 6;

  logic             clk = 1'b0, rst = 1'b1;
  logic             i_req_valid = 1'b0, i_node_pulse = 1'b0, i_node_clr = 1'b0;
  logic [1:0]       i_req_type = '0;
  logic [3:0]       i_req_unit = '0;
  logic             o_req_ready, o_tx, o_busy, o_tx_done;
  logic [CNT_W-1:0] o_num_nodes;

  int checks = 0, fails = 0, done_cnt = 0;
  logic [7:0] rx_q[$];

  bt_msg_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_type(i_req_type), .i_req_unit(i_req_unit), .i_node_pulse(i_node_pulse),
    .i_node_clr(i_node_clr), .o_num_nodes(o_num_nodes), .o_tx(o_tx), .o_busy(o_busy),
    .o_tx_done(o_tx_done));

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && o_tx_done) done_cnt++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Line receiver: samples mid-bit, checks stop bit, abandons a frame on reset.
  initial begin
    logic [7:0] b;
    bit ab;
    forever begin
      @(negedge o_tx);
      if (rst) continue;
      ab = 0;
      b  = '0;
      repeat (BIT / 2) @(posedge clk);
      #1;
      if (rst) ab = 1;
      for (int k = 0; k < 8 && !ab; k++) begin
        repeat (BIT) @(posedge clk);
        #1;
        if (rst) ab = 1; else b[k] = o_tx;
      end
      if (!ab) begin
        repeat (BIT) @(posedge clk);
        #1;
        if (!rst) begin
          chk("stop_bit", int'(o_tx), 1);
          rx_q.push_back(b);
        end
      end
    end
  end

  task automatic push(input logic [1:0] t, input logic [3:0] u);
    int n = 0;
    @(negedge clk);
    i_req_valid = 1'b1; i_req_type = t; i_req_unit = u;
    while (!o_req_ready && n < 20000) begin @(negedge clk); n++; end
    if (!o_req_ready) begin
      fails++; checks++;
      $display("FAIL push_timeout: ready never rose");
    end
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); i_node_pulse = 1'b1;
      @(negedge clk); i_node_pulse = 1'b0;
    end
  endtask

  task automatic clr_nodes();
    @(negedge clk); i_node_clr = 1'b1;
    @(negedge clk); i_node_clr = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 20000) begin @(posedge clk); n++; end
    repeat (3) @(posedge clk);
    chk("tx_done_count", done_cnt, target);
  endtask

  task automatic chk_rx(input string name, input string exp);
    string s = "";
    foreach (rx_q[i]) s = $sformatf("%s%c", s, rx_q[i]);
    checks++;
    if (s != exp) begin
      fails++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, s, exp);
    end
    rx_q.delete();
  endtask

  typedef struct {
    logic [1:0] t;
    logic [3:0] u;
    int         pulses;
    int         exp_nodes;
    string      exp_s;
  } vec_t;

  vec_t vt[8];

  initial begin
    int n, d0;
    vt[0] = '{2'd0, 4'd3,  0,  0, "FIM-3-#"};
    vt[1] = '{2'd2, 4'd0,  5,  5, "NDC-05-#"};
    vt[2] = '{2'd2, 4'd0, 70, 63, "NDC-63-#"};
    vt[3] = '{2'd1, 4'd12, 0,  0, "BDM-9-#"};
    vt[4] = '{2'd3, 4'd5,  0,  0, "RST-#"};
    vt[5] = '{2'd1, 4'd0,  0,  0, "BDM-0-#"};
    vt[6] = '{2'd0, 4'd9, 12, 12, "FIM-9-#"};
    vt[7] = '{2'd2, 4'd1, 12, 12, "NDC-12-#"};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", int'(o_tx), 1);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_ready", int'(o_req_ready), 1);
    chk("rst_nodes", int'(o_num_nodes), 0);
    @(negedge clk); rst = 1'b0;

    // Latency and frame length for a single message into an idle queue.
    push(2'd0, 4'd3);
    chk("lat_idle_busy", int'(o_busy), 0);
    @(posedge clk); #1;
    chk("lat_pop_busy", int'(o_busy), 1);
    chk("lat_pop_tx", int'(o_tx), 1);
    @(posedge clk); #1;
    chk("lat_start_tx", int'(o_tx), 0);
    n = 0;
    while (!o_tx_done && n < 2000) begin @(posedge clk); #1; n++; end
    chk("frame_cycles", n, 7 * 10 * BIT);
    chk("done_busy_low", int'(o_busy), 0);
    @(posedge clk); #1;
    chk("done_one_cycle", int'(o_tx_done), 0);
    wait_done(1);
    chk_rx("msg_fim3", "FIM-3-#");

    foreach (vt[i]) begin
      clr_nodes();
      pulses(vt[i].pulses);
      @(negedge clk);
      chk($sformatf("vec%0d_nodes", i), int'(o_num_nodes), vt[i].exp_nodes);
      d0 = done_cnt;
      push(vt[i].t, vt[i].u);
      wait_done(d0 + 1);
      chk_rx($sformatf("vec%0d_msg", i), vt[i].exp_s);
    end

    // Queue fills while a frame is in flight; fifth request is held until space frees.
    clr_nodes();
    d0 = done_cnt;
    push(2'd0, 4'd1);
    repeat (3) @(posedge clk);
    push(2'd1, 4'd2);
    push(2'd2, 4'd0);
    push(2'd3, 4'd0);
    push(2'd0, 4'd4);
    chk("full_ready_low", int'(o_req_ready), 0);
    @(negedge clk);
    i_req_valid = 1'b1; i_req_type = 2'd1; i_req_unit = 4'd5;
    repeat (20) @(negedge clk);
    chk("full_held", int'(o_req_ready), 0);
    push(2'd1, 4'd5);
    wait_done(d0 + 6);
    chk_rx("queue_order", "FIM-1-#BDM-2-#NDC-00-#RST-#FIM-4-#BDM-5-#");

    // Reset during data bit 3 of char 2 ('T' = 0x54, bit 3 is 0).
    d0 = done_cnt;
    push(2'd3, 4'd0);
    push(2'd0, 4'd1);
    push(2'd1, 4'd2);
    repeat (BIT * 24 + 5 - 2) @(posedge clk);
    #1;
    chk("mid_bit3_low", int'(o_tx), 0);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("rst_tx_immediate", int'(o_tx), 1);
    chk("rst_ready_high", int'(o_req_ready), 1);
    chk("rst_busy_low", int'(o_busy), 0);
    repeat (15) @(negedge clk);
    rx_q.delete();
    rst = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    chk("rst_no_done", done_cnt, d0);
    chk("rst_queue_empty", rx_q.size(), 0);
    chk("rst_idle_after", int'(o_busy), 0);
    push(2'd0, 4'd7);
    wait_done(d0 + 1);
    chk_rx("after_rst_msg", "FIM-7-#");

    // Clear wins over a same-cycle rising edge.
    clr_nodes();
    pulses(7);
    @(negedge clk);
    chk("cnt_seven", int'(o_num_nodes), 7);
    i_node_pulse = 1'b1; i_node_clr = 1'b1;
    @(negedge clk);
    chk("clr_priority", int'(o_num_nodes), 0);
    i_node_pulse = 1'b0; i_node_clr = 1'b0;
    pulses(1);
    @(negedge clk);
    chk("cnt_after_clr", int'(o_num_nodes), 1);

    // Back-to-back frames: one IDLE cycle and one POP cycle between them.
    d0 = done_cnt;
    push(2'd3, 4'd0);
    push(2'd0, 4'd2);
    n = 0;
    while (!o_tx_done && n < 2000) begin @(posedge clk); #1; n++; end
    chk("b2b_idle_tx", int'(o_tx), 1);
    chk("b2b_idle_busy", int'(o_busy), 0);
    @(posedge clk); #1;
    chk("b2b_pop_busy", int'(o_busy), 1);
    chk("b2b_pop_tx", int'(o_tx), 1);
    @(posedge clk); #1;
    chk("b2b_start_tx", int'(o_tx), 0);
    wait_done(d0 + 2);
    chk_rx("b2b_msgs", "RST-#FIM-2-#");

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
